// File: rtl/ahblite_simple_master.sv
// -----------------------------------------------------------------------------
// ahblite_simple_master
//
// Single-beat AHB-Lite initiator. Commands arrive on a valid/ready port and are
// issued as pipelined NONSEQ/SINGLE transfers. Each command produces exactly one
// response pulse that carries the read data and an error flag.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake
//   cmd_addr, cmd_write,   transfer address, direction, size (3 -> word) and
//   cmd_size, cmd_wdata    write data (byte lanes already placed by the caller)
//   HADDR..HMASTLOCK       AHB-Lite address-phase outputs
//   HWDATA                 write data for the current data phase
//   HRDATA, HREADY, HRESP  AHB-Lite slave response inputs
//   rsp_valid, rsp_rdata,  one-cycle response pulse per completed command
//   rsp_err
//   busy                   address or data phase outstanding
// -----------------------------------------------------------------------------
module ahblite_simple_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   // Size encoding 3 is not a legal 32-bit-bus size; saturate it to a word.
   function automatic logic [2:0] clamp_size(input logic [1:0] sz);
      return (sz == 2'd3) ? 3'b010 : {1'b0, sz};
   endfunction

   // Address-phase (A) and data-phase (D) stage registers.
   logic        a_valid;
   logic [31:0] a_addr;
   logic        a_write;
   logic [2:0]  a_size;
   logic [31:0] a_wdata;
   logic        d_valid;
   logic        d_write;
   logic [31:0] d_wdata;

   logic        accept;
   logic        err_first_cycle;
   logic        d_done;

   assign cmd_ready = !a_valid || HREADY;
   assign accept    = cmd_valid && cmd_ready;
   assign d_done    = d_valid && HREADY;

   // First cycle of a two-cycle ERROR: the pending address phase must be
   // withdrawn (IDLE) and is re-driven in the second cycle from the held A stage.
   assign err_first_cycle = d_valid && HRESP && !HREADY;

   assign HTRANS    = (a_valid && !err_first_cycle) ? TRANS_NONSEQ : TRANS_IDLE;
   assign HADDR     = a_addr;
   assign HWRITE    = a_write;
   assign HSIZE     = a_size;
   assign HWDATA    = d_wdata;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;
   assign busy      = a_valid || d_valid;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid   <= 1'b0;
         a_addr    <= '0;
         a_write   <= 1'b0;
         a_size    <= '0;
         a_wdata   <= '0;
         d_valid   <= 1'b0;
         d_write   <= 1'b0;
         d_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         // ---- command port -> A stage ----
         if (accept) begin
            a_valid <= 1'b1;
            a_addr  <= cmd_addr;
            a_write <= cmd_write;
            a_size  <= clamp_size(cmd_size);
            a_wdata <= cmd_wdata;
         end else if (HREADY) begin
            a_valid <= 1'b0;
         end

         // ---- A stage -> D stage (only on a ready edge; waits hold both) ----
         if (HREADY) begin
            d_valid <= a_valid;
            d_write <= a_write;
            d_wdata <= a_wdata;
         end

         // ---- D stage -> response ----
         rsp_valid <= d_done;
         if (d_done) begin
            rsp_err   <= HRESP;
            rsp_rdata <= (!d_write && !HRESP) ? HRDATA : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_ahblite_simple_master.sv
// -----------------------------------------------------------------------------
// tb_ahblite_simple_master
//
// Self-checking bench for ahblite_simple_master. Directed scenarios cover reset,
// single read, back-to-back pipelining, wait states, two-cycle ERROR, size
// clamping and mid-transfer reset; a randomized run is checked against a
// transaction-level model that counts ready edges per in-flight command.
// -----------------------------------------------------------------------------
module tb_ahblite_simple_master;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  hsize;
      logic [31:0] wdata;
      int          phases;   // ready edges seen since acceptance
   } txn_t;

   ahblite_simple_master #(.HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic [31:0] a, input logic w,
                          input logic [1:0] s, input logic [31:0] wd);
      cmd_valid = v; cmd_addr = a; cmd_write = w; cmd_size = s; cmd_wdata = wd;
   endtask

   task automatic test_reset();
      HRESETn = 1'b1;
      set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 32'h0);
      HREADY = 1'b0; HRESP = 1'b0; HRDATA = 32'h0;
      #2 HRESETn = 1'b0;
      #1;
      n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
      n_cmp++; if ({HADDR, HWRITE, HSIZE, HWDATA} !== 68'h0) begin n_bad++; $display("FAIL rst_bus: got %h %h %h %h want all 0", HADDR, HWRITE, HSIZE, HWDATA); end
      n_cmp++; if ({rsp_valid, rsp_rdata, rsp_err} !== 34'h0) begin n_bad++; $display("FAIL rst_rsp: got %b %h %b want 0", rsp_valid, rsp_rdata, rsp_err); end
      n_cmp++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL rst_busy_ready: got %b%b want 01", busy, cmd_ready); end
      n_cmp++; if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin n_bad++; $display("FAIL rst_const: got %h %h %b want 0 3 0", HBURST, HPROT, HMASTLOCK); end
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1; HREADY = 1'b1;
      #1;
      n_cmp++; if ({rsp_valid, busy, HTRANS} !== 4'b0000) begin n_bad++; $display("FAIL rst_release_idle: got %b%b%h want idle", rsp_valid, busy, HTRANS); end
      tick();
   endtask

   task automatic test_single_read();
      set_cmd(1'b1, 32'h4000_0000, 1'b0, 2'd2, 32'h0); HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL sr_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL sr_idle_before: got %h want 0", HTRANS); end
      tick();
      cmd_valid = 1'b0;
      #1;
      n_cmp++; if (HTRANS !== 2'b10) begin n_bad++; $display("FAIL sr_nonseq: got %h want 2", HTRANS); end
      n_cmp++; if ({HADDR, HWRITE, HSIZE} !== {32'h4000_0000, 1'b0, 3'b010}) begin n_bad++; $display("FAIL sr_addr_phase: got %h %b %h want 40000000 0 2", HADDR, HWRITE, HSIZE); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sr_busy: got %b want 1", busy); end
      tick();
      HRDATA = 32'h0000_000A;
      #1;
      n_cmp++; if ({HTRANS, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL sr_data_phase: got %h %b want 0 0", HTRANS, rsp_valid); end
      tick();
      HRDATA = 32'hFFFF_FFFF;
      #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL sr_rsp_valid: got %b want 1", rsp_valid); end
      n_cmp++; if ({rsp_rdata, rsp_err} !== {32'h0000_000A, 1'b0}) begin n_bad++; $display("FAIL sr_rsp_data: got %h %b want 0000000a 0", rsp_rdata, rsp_err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sr_busy_done: got %b want 0", busy); end
      tick();
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL sr_rsp_pulse: got %b want 0", rsp_valid); end
      tick();
   endtask

   task automatic test_back_to_back();
      set_cmd(1'b1, 32'h4000_0010, 1'b1, 2'd2, 32'h0000_0001); HREADY = 1'b1; HRESP = 1'b0;
      #1;
      tick();
      set_cmd(1'b1, 32'h4000_0000, 1'b0, 2'd2, 32'h0);
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
      n_cmp++; if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h4000_0010, 1'b1}) begin n_bad++; $display("FAIL b2b_wr_addr: got %h %h %b want 2 40000010 1", HTRANS, HADDR, HWRITE); end
      tick();
      cmd_valid = 1'b0; HRDATA = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h4000_0000, 1'b0}) begin n_bad++; $display("FAIL b2b_rd_addr: got %h %h %b want 2 40000000 0", HTRANS, HADDR, HWRITE); end
      n_cmp++; if (HWDATA !== 32'h0000_0001) begin n_bad++; $display("FAIL b2b_hwdata: got %h want 00000001", HWDATA); end
      tick();
      HRDATA = 32'h1234_5678;
      #1;
      n_cmp++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin n_bad++; $display("FAIL b2b_wr_rsp: got %b %h %b want 1 0 0", rsp_valid, rsp_rdata, rsp_err); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h1234_5678, 1'b0}) begin n_bad++; $display("FAIL b2b_rd_rsp: got %b %h %b want 1 12345678 0", rsp_valid, rsp_rdata, rsp_err); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_end: got %b%b want 00", rsp_valid, busy); end
      tick();
   endtask

   task automatic test_wait_states();
      set_cmd(1'b1, 32'h4000_0020, 1'b1, 2'd2, 32'hCAFE_F00D); HREADY = 1'b1; HRESP = 1'b0;
      #1;
      tick();
      set_cmd(1'b1, 32'h4000_0024, 1'b0, 2'd2, 32'h0);
      #1;
      tick();
      for (int w = 0; w < 3; w++) begin
         set_cmd(1'b1, 32'h4000_0028, 1'b0, 2'd2, 32'h0); HREADY = 1'b0; HRDATA = $urandom;
         #1;
         n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ws_ready_%0d: got %b want 0", w, cmd_ready); end
         n_cmp++; if ({HTRANS, HADDR, HWDATA} !== {2'b10, 32'h4000_0024, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL ws_stable_%0d: got %h %h %h want 2 40000024 cafef00d", w, HTRANS, HADDR, HWDATA); end
         n_cmp++; if ({rsp_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL ws_hold_%0d: got %b%b want 01", w, rsp_valid, busy); end
         tick();
      end
      HREADY = 1'b1;
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ws_ready_release: got %b want 1", cmd_ready); end
      tick();
      cmd_valid = 1'b0; HRDATA = 32'h0000_0077;
      #1;
      n_cmp++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin n_bad++; $display("FAIL ws_wr_rsp: got %b %h %b want 1 0 0", rsp_valid, rsp_rdata, rsp_err); end
      n_cmp++; if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0028}) begin n_bad++; $display("FAIL ws_third_addr: got %h %h want 2 40000028", HTRANS, HADDR); end
      tick();
      HRDATA = 32'h0000_0088;
      #1;
      n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_0077}) begin n_bad++; $display("FAIL ws_rd1_rsp: got %b %h want 1 00000077", rsp_valid, rsp_rdata); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_0088}) begin n_bad++; $display("FAIL ws_rd2_rsp: got %b %h want 1 00000088", rsp_valid, rsp_rdata); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL ws_end: got %b%b want 00", rsp_valid, busy); end
      tick();
   endtask

   task automatic test_error();
      set_cmd(1'b1, 32'h4000_0030, 1'b1, 2'd2, 32'h0000_0005); HREADY = 1'b1; HRESP = 1'b0;
      #1;
      tick();
      set_cmd(1'b1, 32'h4000_0034, 1'b0, 2'd2, 32'h0);
      #1;
      tick();
      cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
      #1;
      n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_cancel: got %h want 0", HTRANS); end
      n_cmp++; if ({cmd_ready, busy, rsp_valid} !== 3'b010) begin n_bad++; $display("FAIL err_c1_ctrl: got %b%b%b want 010", cmd_ready, busy, rsp_valid); end
      tick();
      HREADY = 1'b1; HRESP = 1'b1;
      #1;
      n_cmp++; if ({HTRANS, HADDR, HWDATA} !== {2'b10, 32'h4000_0034, 32'h5}) begin n_bad++; $display("FAIL err_redrive: got %h %h %h want 2 40000034 5", HTRANS, HADDR, HWDATA); end
      tick();
      HRESP = 1'b0; HRDATA = 32'h0000_0099;
      #1;
      n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL err_wr_rsp: got %b %b %h want 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
      n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_no_dup: got %h want 0", HTRANS); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000_0099}) begin n_bad++; $display("FAIL err_rd_rsp: got %b %b %h want 1 0 00000099", rsp_valid, rsp_err, rsp_rdata); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL err_end: got %b%b want 00", rsp_valid, busy); end
      tick();
   endtask

   task automatic test_size();
      set_cmd(1'b1, 32'h4000_0001, 1'b0, 2'd3, 32'h0); HREADY = 1'b1; HRESP = 1'b0;
      #1;
      tick();
      set_cmd(1'b1, 32'h4000_0003, 1'b0, 2'd0, 32'h0);
      #1;
      n_cmp++; if ({HSIZE, HADDR} !== {3'b010, 32'h4000_0001}) begin n_bad++; $display("FAIL sz_3: got %h %h want 2 40000001", HSIZE, HADDR); end
      tick();
      set_cmd(1'b1, 32'h4000_0002, 1'b0, 2'd1, 32'h0);
      #1;
      n_cmp++; if ({HSIZE, HADDR} !== {3'b000, 32'h4000_0003}) begin n_bad++; $display("FAIL sz_0: got %h %h want 0 40000003", HSIZE, HADDR); end
      tick();
      cmd_valid = 1'b0;
      #1;
      n_cmp++; if (HSIZE !== 3'b001) begin n_bad++; $display("FAIL sz_1: got %h want 1", HSIZE); end
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      set_cmd(1'b1, 32'h4000_0040, 1'b0, 2'd2, 32'h0); HREADY = 1'b1; HRESP = 1'b0;
      #1;
      tick();
      set_cmd(1'b1, 32'h4000_0044, 1'b0, 2'd2, 32'h0);
      #1;
      tick();
      cmd_valid = 1'b0; HREADY = 1'b0;
      #1;
      HRESETn = 1'b0;
      #1;
      n_cmp++; if ({HTRANS, busy} !== 3'b000) begin n_bad++; $display("FAIL rm_async: got %h %b want 0 0", HTRANS, busy); end
      n_cmp++; if ({cmd_ready, rsp_valid, HADDR} !== {1'b1, 1'b0, 32'h0}) begin n_bad++; $display("FAIL rm_state: got %b %b %h want 1 0 0", cmd_ready, rsp_valid, HADDR); end
      tick();
      HREADY = 1'b1;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp_in_rst: got %b want 0", rsp_valid); end
      HRESETn = 1'b1;
      tick();
      #1;
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rm_no_rsp_after: got %b%b want 00", rsp_valid, busy); end
      tick();
      set_cmd(1'b1, 32'h4000_0048, 1'b0, 2'd2, 32'h0);
      #1;
      tick();
      cmd_valid = 1'b0;
      #1;
      n_cmp++; if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0048}) begin n_bad++; $display("FAIL rm_new_addr: got %h %h want 2 40000048", HTRANS, HADDR); end
      tick();
      HRDATA = 32'h0000_4242;
      #1;
      tick();
      #1;
      n_cmp++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0000_4242, 1'b0}) begin n_bad++; $display("FAIL rm_new_rsp: got %b %h %b want 1 00004242 0", rsp_valid, rsp_rdata, rsp_err); end
      tick();
   endtask

   // Reference model: each accepted command is an entry that counts ready edges.
   // 0 edges -> in address phase, 1 -> in data phase, 2 -> completed.
   task automatic test_random();
      txn_t        q[$];
      txn_t        t;
      int          a_idx;
      int          d_idx;
      logic        exp_ready;
      logic        exp_rsp_v;
      logic [31:0] exp_rsp_d;
      bit          quiet;
      exp_rsp_v = 1'b0;
      exp_rsp_d = 32'h0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         quiet = (cyc >= 390);
         set_cmd(quiet ? 1'b0 : ($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom);
         HREADY = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
         HRESP = 1'b0;
         HRDATA = $urandom;
         #1;
         a_idx = -1;
         d_idx = -1;
         foreach (q[i]) begin
            if (q[i].phases == 0) a_idx = i;
            else if (q[i].phases == 1) d_idx = i;
         end
         exp_ready = (a_idx < 0) || HREADY;
         n_cmp++; if (cmd_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, cmd_ready, exp_ready); end
         n_cmp++; if (HTRANS !== ((a_idx >= 0) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL rnd_htrans c%0d: got %h want %0d", cyc, HTRANS, (a_idx >= 0) ? 2 : 0); end
         n_cmp++; if (busy !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, q.size() != 0); end
         if (a_idx >= 0) begin
            n_cmp++; if ({HADDR, HWRITE, HSIZE} !== {q[a_idx].addr, q[a_idx].wr, q[a_idx].hsize}) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h %b %h want %h %b %h", cyc, HADDR, HWRITE, HSIZE, q[a_idx].addr, q[a_idx].wr, q[a_idx].hsize); end
         end
         if (d_idx >= 0 && q[d_idx].wr) begin
            n_cmp++; if (HWDATA !== q[d_idx].wdata) begin n_bad++; $display("FAIL rnd_hwdata c%0d: got %h want %h", cyc, HWDATA, q[d_idx].wdata); end
         end
         n_cmp++; if (rsp_valid !== exp_rsp_v) begin n_bad++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, exp_rsp_v); end
         if (exp_rsp_v) begin
            n_cmp++; if ({rsp_rdata, rsp_err} !== {exp_rsp_d, 1'b0}) begin n_bad++; $display("FAIL rnd_rsp_data c%0d: got %h %b want %h 0", cyc, rsp_rdata, rsp_err, exp_rsp_d); end
         end
         // advance the model across the coming edge
         exp_rsp_v = 1'b0;
         if (HREADY) begin
            foreach (q[i]) q[i].phases++;
            if (q.size() > 0 && q[0].phases == 2) begin
               t = q.pop_front();
               exp_rsp_v = 1'b1;
               exp_rsp_d = t.wr ? 32'h0 : HRDATA;
            end
         end
         if (cmd_valid && exp_ready) begin
            t.addr   = cmd_addr;
            t.wr     = cmd_write;
            t.hsize  = (cmd_size == 2'd3) ? 3'd2 : {1'b0, cmd_size};
            t.wdata  = cmd_wdata;
            t.phases = 0;
            q.push_back(t);
         end
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_wait_states();
      test_error();
      test_size();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahblite_simple_master.md
Name: ahblite_simple_master

Overview:
- Single-beat AHB-Lite initiator.
- Accepts read/write commands on a valid/ready port and issues them as pipelined NONSEQ/SINGLE transfers toward the bus matrix.
- Returns one response per command: read data plus error flag.
- Used by hardware sequencers and test harnesses to poll/drive AHB-Lite peripherals (switch, LED, timer slaves) without the Cortex-M0.

Parameters:
HPROT_VAL, 4'b0011, constant driven on HPROT (data, privileged, non-bufferable).
Command address width is fixed at 32 and data width at 32; neither is parameterised.

Ports:
HCLK  input  1  clock
HRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at HCLK edge
cmd_addr  input  32  transfer address
cmd_write  input  1  1 = write, 0 = read
cmd_size  input  2  0 byte, 1 half, 2 word, 3 treated as word
cmd_wdata  input  32  write data, driven unmodified on HWDATA (caller places byte lanes)
HADDR  output  32  AHB address
HTRANS  output  2  IDLE (2'b00) or NONSEQ (2'b10) only
HWRITE  output  1  AHB direction
HSIZE  output  3  {1'b0, clamped cmd_size}
HBURST  output  3  constant 3'b000 (SINGLE)
HPROT  output  4  HPROT_VAL
HMASTLOCK  output  1  constant 0
HWDATA  output  32  write data for the current data phase
HRDATA  input  32  read data
HREADY  input  1  bus ready
HRESP  input  1  0 OKAY, 1 ERROR
rsp_valid  output  1  one-cycle pulse per completed command
rsp_rdata  output  32  captured HRDATA (reads); 0 for writes
rsp_err  output  1  transfer ended with ERROR
busy  output  1  address or data phase outstanding

Behaviour:
- State: A stage (a_valid, a_addr, a_write, a_size, a_wdata) and D stage (d_valid, d_write, d_wdata). Both stages may be occupied simultaneously (pipelining).
- Reset (async):
  - a_valid = d_valid = 0.
  - HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - busy = 0, cmd_ready = 1.
  - Reset mid-transfer abandons all work; no response is generated for abandoned commands.
- cmd_ready = !a_valid | HREADY (combinational).
- Accept (cmd_valid & cmd_ready): load A stage from the command at the edge, a_valid = 1.
  - If no command is accepted and A advances, a_valid becomes 0.
- HADDR, HWRITE, HSIZE come from A-stage registers.
- HTRANS = NONSEQ when a_valid & !(d_valid & HRESP & !HREADY); otherwise IDLE.
- Edge with HREADY = 1:
  - A moves to D: d_valid = a_valid, d_write/d_wdata copied.
  - If d_valid was set, the old D completes.
- Edge with HREADY = 0: A and D hold.
- HWDATA = d_wdata register; it is stable through every wait state.
- Completion at edge E (d_valid & HREADY):
  - Next cycle: rsp_valid = 1.
  - rsp_err = HRESP sampled at E.
  - rsp_rdata = HRDATA for a read with OKAY; 0 for writes and errors.
  - rsp_valid is otherwise 0. There is no response backpressure.
- Latency with zero wait states: command accepted at edge T0, address phase T0–T1, data phase T1–T2, rsp_valid during T2–T3.
- Throughput: one command per cycle when cmd_valid is held and HREADY = 1.
- ERROR handling (two-cycle HRESP):
  - Cycle 1 (HRESP = 1, HREADY = 0): a pending A-stage transfer drives HTRANS = IDLE (cancelled).
  - Cycle 2 (HRESP = 1, HREADY = 1): NONSEQ is re-driven and the transfer is sampled at that edge.
  - The pending command is never dropped and never duplicated.
- Single-cycle HRESP = 1 with HREADY = 1 (protocol violation): treated as an error completion. No special cancellation.
- busy = a_valid | d_valid.
- No address-alignment checking. A misaligned address is issued as given.

Test Plan:
- Single read of 0x4000_0000, HREADY = 1, HRDATA = 0x0000_000A → HTRANS NONSEQ for exactly 1 cycle, rsp_valid 2 cycles after accept, rsp_rdata = 0xA, rsp_err = 0.
- Back-to-back write 0x4000_0010 / 0x1 then read 0x4000_0000, both offered on consecutive cycles → second address phase overlaps first data phase, HWDATA = 0x1 in the correct cycle, two rsp_valid pulses on consecutive cycles.
- Read with 3 wait states (HREADY low 3 cycles) → HADDR, HTRANS and HWDATA stable throughout, cmd_ready = 0 while a_valid, response 3 cycles later than the zero-wait case.
- Write followed by pipelined read; slave returns two-cycle ERROR on the write → HTRANS = IDLE in cycle 1, NONSEQ in cycle 2, write response rsp_err = 1, read subsequently completes with rsp_err = 0.
- cmd_size = 3 → HSIZE = 3'b010; cmd_size = 0 → HSIZE = 3'b000.
- HRESETn asserted during a waited data phase → HTRANS = IDLE and busy = 0 immediately (asynchronously), no rsp_valid; a command issued after release completes normally.
